// File: rtl/adder_full_nbit.sv
// Registered n-bit ripple-carry adder built from one full-adder stage per bit.
// Define ADDER_FULL_NBIT_OVF_EN to add the registered signed-overflow output ovf.
module adder_full_nbit #(
   parameter int n = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [n-1:0] X,
   input  logic [n-1:0] Y,
   input  logic         Cin,
   output logic [n-1:0] sum,
   output logic         carry,
   output logic         out_valid
`ifdef ADDER_FULL_NBIT_OVF_EN
   ,
   output logic         ovf
`endif
);

   logic [n:0]   c;
   logic [n-1:0] s;

   logic [n-1:0] sum_d, sum_q;
   logic         carry_d, carry_q;
   logic         out_valid_d, out_valid_q;

   assign c[0] = Cin;

   // One full-adder cell per bit; each stage sees only its own operand bits and incoming carry.
   for (genvar i = 0; i < n; i++) begin : g_stage
      assign s[i]   = X[i] ^ Y[i] ^ c[i];
      assign c[i+1] = (X[i] & Y[i]) | (c[i] & (X[i] ^ Y[i]));
   end

   always_comb begin
      sum_d       = sum_q;
      carry_d     = carry_q;
      out_valid_d = in_valid;
      if (in_valid) begin
         sum_d   = s;
         carry_d = c[n];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q       <= '0;
         carry_q     <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         sum_q       <= sum_d;
         carry_q     <= carry_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign sum       = sum_q;
   assign carry     = carry_q;
   assign out_valid = out_valid_q;

`ifdef ADDER_FULL_NBIT_OVF_EN
   logic ovf_d, ovf_q;

   // Signed overflow: carry into the sign bit differs from carry out of it.
   always_comb begin
      ovf_d = ovf_q;
      if (in_valid) ovf_d = c[n] ^ c[n-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ovf_q <= 1'b0;
      else     ovf_q <= ovf_d;
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_adder_full_nbit.sv
// Bench for adder_full_nbit: directed stage sweeps, wrap, hold, async reset and random adds
// checked against an arithmetic reference model.
module tb_adder_full_nbit;
   localparam int n = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic [n-1:0] X = '0;
   logic [n-1:0] Y = '0;
   logic         Cin = 1'b0;
   logic [n-1:0] sum;
   logic         carry;
   logic         out_valid;
`ifdef ADDER_FULL_NBIT_OVF_EN
   logic         ovf;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state: last captured result, held while in_valid is low.
   logic [n-1:0] m_sum = '0;
   logic         m_carry = 1'b0;
   logic         m_ovf = 1'b0;
   logic [n+1:0] exp_q[$];

   adder_full_nbit #(.n(n)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .X         (X),
      .Y         (Y),
      .Cin       (Cin),
      .sum       (sum),
      .carry     (carry),
      .out_valid (out_valid)
`ifdef ADDER_FULL_NBIT_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one input cycle, let the model predict, then check the registered outputs.
   task automatic apply(input string tag, input logic v, input logic [n-1:0] x,
                        input logic [n-1:0] y, input logic ci);
      logic [n:0]   tot;
      int           r;
      logic [n+1:0] e;
      @(negedge clk);
      in_valid = v;
      X        = x;
      Y        = y;
      Cin      = ci;
      if (v) begin
         tot     = {1'b0, x} + {1'b0, y} + {{n{1'b0}}, ci};
         m_sum   = tot[n-1:0];
         m_carry = tot[n];
         r       = int'($signed(x)) + int'($signed(y)) + int'(ci);
         m_ovf   = (r > (2 ** (n - 1)) - 1) || (r < -(2 ** (n - 1)));
      end
      exp_q.push_back({m_ovf, m_carry, m_sum});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check({tag, ".sum"}, 64'(sum), 64'(e[n-1:0]));
      check({tag, ".carry"}, 64'(carry), 64'(e[n]));
      check({tag, ".out_valid"}, 64'(out_valid), 64'(v));
`ifdef ADDER_FULL_NBIT_OVF_EN
      check({tag, ".ovf"}, 64'(ovf), 64'(e[n+1]));
`endif
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, ".sum"}, 64'(sum), 64'd0);
      check({tag, ".carry"}, 64'(carry), 64'd0);
      check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
`ifdef ADDER_FULL_NBIT_OVF_EN
      check({tag, ".ovf"}, 64'(ovf), 64'd0);
`endif
   endtask

   initial begin
      logic [2:0]   q;
      logic [n-1:0] x, y;

      // Reset held from time zero.
      #3;
      check_reset_state("reset_init");
      @(negedge clk);
      rst = 1'b0;

      // Zero add: no bit may be stuck at one.
      apply("zero", 1'b1, 8'h00, 8'h00, 1'b0);
      check("zero.explicit", 64'({carry, sum}), 64'h000);

      // Stage 0: sweep {Cin,X[0],Y[0]}.
      for (int p = 1; p <= 6; p++) begin
         q = 3'(p);
         apply($sformatf("stage0_p%0d", p), 1'b1, {7'b0, q[1]}, {7'b0, q[0]}, q[2]);
      end

      // Stage j: carry into stage j is generated by X[j-1]&Y[j-1] with Y[j-1]=1.
      for (int j = 1; j < n; j++) begin
         for (int p = 1; p <= 6; p++) begin
            q = 3'(p);
            x = (8'(q[2]) << (j - 1)) | (8'(q[1]) << j);
            y = (8'd1 << (j - 1)) | (8'(q[0]) << j);
            apply($sformatf("stage%0d_p%0d", j, p), 1'b1, x, y, 1'b0);
         end
      end
      apply("stage3_q101", 1'b1, 8'h04, 8'h0C, 1'b0);
      check("stage3_q101.explicit", 64'({carry, sum}), 64'h010);

      // Wrap-around and sign overflow.
      apply("wrap_ff", 1'b1, 8'hFF, 8'hFF, 1'b1);
      check("wrap_ff.explicit", 64'({carry, sum}), 64'h1FF);
      apply("wrap_80", 1'b1, 8'h80, 8'h80, 1'b0);
      check("wrap_80.explicit", 64'({carry, sum}), 64'h100);
`ifdef ADDER_FULL_NBIT_OVF_EN
      check("wrap_80.ovf_explicit", 64'(ovf), 64'd1);
`endif

      // Hold: idle cycle must keep the previous result.
      apply("hold_load", 1'b1, 8'h12, 8'h34, 1'b0);
      apply("hold_idle", 1'b0, 8'hFF, 8'hFF, 1'b1);
      check("hold_idle.explicit", 64'({out_valid, carry, sum}), 64'h046);

      // Asynchronous reset mid-stream, away from any clock edge.
      apply("pre_rst", 1'b1, 8'hFF, 8'hFF, 1'b1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_reset_state("async_rst");
      m_sum   = '0;
      m_carry = 1'b0;
      m_ovf   = 1'b0;
      @(negedge clk);
      check_reset_state("async_rst_held");
      rst = 1'b0;
      apply("post_rst", 1'b1, 8'h01, 8'h02, 1'b1);

      // Random back-to-back adds.
      for (int k = 0; k < 1000; k++) begin
         apply("random", 1'b1, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
